md_sched: RTL and testbench

- Multiply/divide scheduler for the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo commands from the E-stage control.
- Computes each multiply or divide result, then commits it to the architectural HI/LO registers after a fixed latency.
- Drives a busy/stall indication to the D-stage hazard logic, so md-class instructions are held while the unit is occupied.

---
 rtl/md_sched.sv | 141 ++++++++++++++
 tb/tb_md_sched.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler for the MIPS E stage.
// Computes mult/multu/div/divu results at the accept edge into shadow
// registers, then commits them to HI/LO after a fixed latency. mthi/mtlo
// write HI/LO directly with zero latency when the unit is idle.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  state_t      r_state;
  logic        r_busy;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_res_hi, r_res_lo;
  logic        r_dz;

  logic               w_md;
  logic               w_bz;
  logic               w_ovf;
  logic        [63:0] w_umul;
  logic signed [63:0] w_smul;
  logic        [31:0] w_udvs;
  logic signed [31:0] w_sa, w_sdvs, w_sq, w_sr;
  logic        [31:0] w_uq, w_ur;

  assign w_md   = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign w_bz   = (B == 32'd0);
  // INT_MIN / -1 is replaced by INT_MIN / 1, which yields exactly the
  // architected quotient 0x80000000 and remainder 0 without overflow.
  assign w_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

  assign w_umul = {32'd0, A} * {32'd0, B};
  assign w_smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});

  // Divisor forced to 1 on zero so the divider never sees x/0; the
  // result is discarded by r_dz in that case.
  assign w_udvs = w_bz ? 32'd1 : B;
  assign w_sa   = $signed(A);
  assign w_sdvs = (w_bz || w_ovf) ? 32'sd1 : $signed(B);
  assign w_sq   = w_sa / w_sdvs;
  assign w_sr   = w_sa % w_sdvs;
  assign w_uq   = A / w_udvs;
  assign w_ur   = A % w_udvs;

  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign stall_md = r_busy | (start & w_md);

  // Accept, countdown and commit FSM; HI/LO change only at commit or mthi/mtlo.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_cnt    <= 4'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (md_op)
              OP_MULT: begin
                {r_res_hi, r_res_lo} <= w_smul;
                r_cnt   <= MC;
                r_dz    <= 1'b0;
                r_busy  <= 1'b1;
                r_state <= S_RUN;
              end
              OP_MULTU: begin
                {r_res_hi, r_res_lo} <= w_umul;
                r_cnt   <= MC;
                r_dz    <= 1'b0;
                r_busy  <= 1'b1;
                r_state <= S_RUN;
              end
              OP_DIV: begin
                r_res_hi <= w_sr;
                r_res_lo <= w_sq;
                r_cnt    <= DC;
                r_dz     <= w_bz;
                r_busy   <= 1'b1;
                r_state  <= S_RUN;
              end
              OP_DIVU: begin
                r_res_hi <= w_ur;
                r_res_lo <= w_uq;
                r_cnt    <= DC;
                r_dz     <= w_bz;
                r_busy   <= 1'b1;
                r_state  <= S_RUN;
              end
              OP_MTHI: r_hi <= A;
              OP_MTLO: r_lo <= A;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (!r_dz) begin
              r_hi <= r_res_hi;
              r_lo <= r_res_lo;
            end
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed checks of md_sched latency, arithmetic, busy
// conflicts, divide-by-zero and mid-operation reset.
module tb_md_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_err = 0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one command for one edge, then scramble operands.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op; A = a; B = b; start = 1'b1;
    step(1);
    start = 1'b0; md_op = 3'd0; A = $urandom; B = $urandom;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
    step(2);
    reset = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall_md}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // mult -2 * 3, with an mthi attempted while busy
    md_op = 3'd1; A = 32'hFFFF_FFFE; B = 32'd3; start = 1'b1;
    #1;
    chk("mult_stall_comb", {31'd0, stall_md}, 32'd1);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    for (int i = 1; i <= 5; i++) begin
      chk("mult_busy", {31'd0, busy}, 32'd1);
      chk("mult_hi_hold", hi, 32'd0);
      chk("mult_lo_hold", lo, 32'd0);
      if (i == 2) begin
        start = 1'b1; md_op = 3'd5; A = 32'h0000_1234;
      end
      step(1);
      start = 1'b0; md_op = 3'd0;
    end
    chk("mult_busy_done", {31'd0, busy}, 32'd0);
    chk("mult_stall_done", {31'd0, stall_md}, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // multu
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    step(4);
    chk("multu_busy", {31'd0, busy}, 32'd1);
    chk("multu_hi_hold", hi, 32'hFFFF_FFFF);
    step(1);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // mthi / mtlo in idle: zero latency
    issue(3'd5, 32'h0000_1234, 32'd0);
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_lo", lo, 32'hFFFF_FFFE);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(3'd6, 32'h0000_CAFE, 32'd0);
    chk("mtlo_lo", lo, 32'h0000_CAFE);
    chk("mtlo_hi", hi, 32'h0000_1234);

    // reserved op: no action, no stall
    md_op = 3'd7; A = 32'h5555_5555; start = 1'b1;
    #1;
    chk("rsv_stall", {31'd0, stall_md}, 32'd0);
    issue(3'd7, 32'h5555_5555, 32'd1);
    chk("rsv_busy", {31'd0, busy}, 32'd0);
    chk("rsv_hi", hi, 32'h0000_1234);

    // div -7 / 2
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    step(9);
    chk("div_busy", {31'd0, busy}, 32'd1);
    chk("div_hi_hold", hi, 32'h0000_1234);
    step(1);
    chk("div_busy_done", {31'd0, busy}, 32'd0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // divu by zero: full latency, HI/LO untouched
    issue(3'd4, 32'd7, 32'd0);
    step(9);
    chk("dz_busy", {31'd0, busy}, 32'd1);
    step(1);
    chk("dz_busy_done", {31'd0, busy}, 32'd0);
    chk("dz_hi", hi, 32'hFFFF_FFFF);
    chk("dz_lo", lo, 32'hFFFF_FFFD);

    // div overflow case
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    step(10);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);

    // divu 100 / 7
    issue(3'd4, 32'd100, 32'd7);
    step(10);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // div 7 / -2
    issue(3'd3, 32'd7, 32'hFFFF_FFFE);
    step(10);
    chk("divn_lo", lo, 32'hFFFF_FFFD);
    chk("divn_hi", hi, 32'd1);

    // reset at T+2 of a div abandons it
    issue(3'd3, 32'd100, 32'd3);
    step(1);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_hi", hi, 32'd0);
    chk("mrst_lo", lo, 32'd0);
    step(10);
    chk("mrst_hi_late", hi, 32'd0);
    chk("mrst_lo_late", lo, 32'd0);
    chk("mrst_busy_late", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
